// File: rtl/pic_cpu_initiator.sv
// CPU-side bus master for an 8259A-style PIC: register write/read strobes and 8086-mode INTA.
// Latency: write = STROBE_CYCLES+2, read = STROBE_CYCLES+1, ack = 2*INTA_LOW+INTA_GAP+1+RECOVER cycles.
// Backpressure: cmd_ready is high only in IDLE with no interrupt pending; commands wait otherwise.
module pic_cpu_initiator #(
  parameter int STROBE_CYCLES   = 2,
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2,
  parameter int RECOVER_CYCLES  = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       INT,
  input  logic       int_enable,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  output logic       busy,
  input  logic [7:0] D_RD,
  output logic [7:0] D_WR,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A0,
  output logic       INTA_n
);

  // Counter reload values; a zero parameter behaves like one cycle.
  localparam logic [3:0] STB_LD = (STROBE_CYCLES   <= 1) ? 4'd0 : 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] LOW_LD = (INTA_LOW_CYCLES <= 1) ? 4'd0 : 4'(INTA_LOW_CYCLES - 1);
  localparam logic [3:0] GAP_LD = (INTA_GAP_CYCLES <= 1) ? 4'd0 : 4'(INTA_GAP_CYCLES - 1);
  localparam logic [3:0] REC_LD = (RECOVER_CYCLES  <= 1) ? 4'd0 : 4'(RECOVER_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_STROBE, R_DONE,
    INTA1, INTA_GAP, INTA2, V_DONE, RECOVER
  } state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       int_q1, int_q2;
  logic       cs_n_q, rd_n_q, wr_n_q, inta_n_q, a0_q;
  logic [7:0] d_wr_q, rd_data_q, vec_data_q;
  logic       rd_valid_q, vec_valid_q;
  logic       int_s;
  logic       ack_req;

  assign int_s   = int_q2;
  assign ack_req = int_s & int_enable;

  // Two-flop synchronizer for the asynchronous INT pin.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      int_q1 <= 1'b0;
      int_q2 <= 1'b0;
    end else begin
      int_q1 <= INT;
      int_q2 <= int_q1;
    end
  end

  // Bus-cycle sequencer; every pin is registered so strobes are glitch-free and reset drives them high at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      inta_n_q    <= 1'b1;
      a0_q        <= 1'b0;
      d_wr_q      <= 8'h00;
      rd_data_q   <= 8'h00;
      vec_data_q  <= 8'h00;
      rd_valid_q  <= 1'b0;
      vec_valid_q <= 1'b0;
    end else begin
      rd_valid_q  <= 1'b0;
      vec_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ack_req) begin
            // Acknowledge wins over a command presented in the same cycle.
            state_q  <= INTA1;
            inta_n_q <= 1'b0;
            cnt_q    <= LOW_LD;
          end else if (cmd_valid) begin
            a0_q   <= cmd_a0;
            cs_n_q <= 1'b0;
            cnt_q  <= STB_LD;
            if (cmd_read) begin
              state_q <= R_STROBE;
              rd_n_q  <= 1'b0;
            end else begin
              state_q <= W_SETUP;
              d_wr_q  <= cmd_data;
            end
          end
        end
        W_SETUP: begin
          state_q <= W_STROBE;
          wr_n_q  <= 1'b0;
          cnt_q   <= STB_LD;
        end
        W_STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q <= W_HOLD;
            wr_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        W_HOLD: begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
        end
        R_STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q    <= R_DONE;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            rd_data_q  <= D_RD;
            rd_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        R_DONE: begin
          state_q <= IDLE;
        end
        INTA1: begin
          if (cnt_q == 4'd0) begin
            state_q  <= INTA_GAP;
            inta_n_q <= 1'b1;
            cnt_q    <= GAP_LD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        INTA_GAP: begin
          if (cnt_q == 4'd0) begin
            state_q  <= INTA2;
            inta_n_q <= 1'b0;
            cnt_q    <= LOW_LD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        INTA2: begin
          if (cnt_q == 4'd0) begin
            state_q     <= V_DONE;
            inta_n_q    <= 1'b1;
            vec_data_q  <= D_RD;
            vec_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        V_DONE: begin
          state_q <= RECOVER;
          cnt_q   <= REC_LD;
        end
        RECOVER: begin
          // INT is still high from the PIC for a while; hold off re-sampling it.
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE) & ~ack_req & ~RESET;
  assign busy      = (state_q != IDLE);
  assign CS_n      = cs_n_q;
  assign RD_n      = rd_n_q;
  assign WR_n      = wr_n_q;
  assign INTA_n    = inta_n_q;
  assign A0        = a0_q;
  assign D_WR      = d_wr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign vec_data  = vec_data_q;
  assign vec_valid = vec_valid_q;

endmodule

// File: tb/tb_pic_cpu_initiator.sv
// Directed bench for pic_cpu_initiator with a small PIC pin model and cycle monitor.
// Latency: checks strobe widths and acknowledge timing in cycles at the negative clock edge.
// Backpressure: commands are held on cmd_valid until cmd_ready accepts them.
module tb_pic_cpu_initiator;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       INT = 1'b0;
  logic       int_enable = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_read = 1'b0;
  logic       cmd_a0 = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       vec_valid;
  logic [7:0] vec_data;
  logic       busy;
  logic [7:0] D_RD;
  logic [7:0] D_WR;
  logic       CS_n, RD_n, WR_n, A0, INTA_n;

  int checks = 0;
  int errors = 0;

  pic_cpu_initiator dut (
    .CLK(CLK), .RESET(RESET), .INT(INT), .int_enable(int_enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_a0(cmd_a0), .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_data(rd_data),
    .vec_valid(vec_valid), .vec_data(vec_data), .busy(busy), .D_RD(D_RD), .D_WR(D_WR),
    .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A0(A0), .INTA_n(INTA_n)
  );

  always #5 CLK = ~CLK;

  // Monitor / PIC model state, updated only at the negative edge.
  int         cyc = 0;
  int         wr_low_tot = 0, rd_low_tot = 0, cs_low_tot = 0;
  int         dwr_chg = 0, viol = 0;
  int         rdv_tot = 0, vecv_tot = 0;
  int         inta_fall = 0, low_run = 0, high_run = 0;
  int         low_len_a = 0, low_len_b = 0, gap_len = 0;
  int         vec_cyc = 0, cs_fall_cyc = 0;
  int         wr_idx = 0;
  logic [7:0] wr_dat_log [0:15];
  logic       wr_a0_log  [0:15];
  logic       prev_cs = 1'b1, prev_wr = 1'b1, prev_inta = 1'b1;
  logic [7:0] prev_dwr = 8'h00;
  logic [7:0] rd_byte = 8'hA5;

  // PIC drives the vector on the second INTA pulse (ICW2 base | IR3) and the status byte on RD.
  assign D_RD = (!INTA_n && inta_fall != 0 && !inta_fall[0]) ? {wr_dat_log[1][7:3], 3'd3} :
                (!RD_n ? rd_byte : 8'h00);

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (!WR_n) wr_low_tot <= wr_low_tot + 1;
    if (!RD_n) rd_low_tot <= rd_low_tot + 1;
    if (!CS_n) cs_low_tot <= cs_low_tot + 1;
    if (!CS_n && !prev_cs && D_WR != prev_dwr) dwr_chg <= dwr_chg + 1;
    if (!CS_n && prev_cs) cs_fall_cyc <= cyc;
    if ((32'(!WR_n) + 32'(!RD_n) + 32'(!INTA_n)) > 1) viol <= viol + 1;
    if (rd_valid) rdv_tot <= rdv_tot + 1;
    if (vec_valid) begin
      vecv_tot <= vecv_tot + 1;
      vec_cyc  <= cyc;
    end
    if (WR_n && !prev_wr && !CS_n) begin
      wr_dat_log[wr_idx[3:0]] <= D_WR;
      wr_a0_log[wr_idx[3:0]]  <= A0;
      wr_idx <= wr_idx + 1;
    end
    if (!INTA_n) begin
      low_run <= prev_inta ? 1 : low_run + 1;
      if (prev_inta) begin
        inta_fall <= inta_fall + 1;
        if (inta_fall[0]) gap_len <= high_run;
      end
    end else begin
      high_run <= prev_inta ? high_run + 1 : 1;
      if (!prev_inta) begin
        if (inta_fall[0]) low_len_a <= low_run;
        else              low_len_b <= low_run;
      end
    end
    prev_cs   <= CS_n;
    prev_wr   <= WR_n;
    prev_inta <= INTA_n;
    prev_dwr  <= D_WR;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negative edge; returns at the negative edge after acceptance.
  task automatic issue(input logic rd, input logic a0, input logic [7:0] dat, input string tag);
    logic ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_read = rd; cmd_a0 = a0; cmd_data = dat;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        @(posedge CLK);
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(negedge CLK);
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_vec(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (vec_valid) break;
      @(negedge CLK);
    end
    chk(tag, 32'(vec_valid), 32'd1);
  endtask

  task automatic do_write(input logic a0, input logic [7:0] dat, input string tag);
    int s_wr, s_cs, s_chg;
    s_wr = wr_low_tot; s_cs = cs_low_tot; s_chg = dwr_chg;
    issue(1'b0, a0, dat, {tag, "_acc"});
    wait_idle({tag, "_idle"});
    @(negedge CLK);
    chk({tag, "_wr_low"}, 32'(wr_low_tot - s_wr), 32'd2);
    chk({tag, "_cs_low"}, 32'(cs_low_tot - s_cs), 32'd4);
    chk({tag, "_dwr_stable"}, 32'(dwr_chg - s_chg), 32'd0);
  endtask

  initial begin
    int s_f, s_v, s_r, s_rd, s_cs;
    // Reset values while RESET is held.
    repeat (2) @(negedge CLK);
    chk("rst_cs", 32'(CS_n), 32'd1);
    chk("rst_strobes", 32'({RD_n, WR_n, INTA_n}), 32'h7);
    chk("rst_a0_dwr", 32'({A0, D_WR}), 32'h0);
    chk("rst_data", 32'({rd_data, vec_data, rd_valid, vec_valid}), 32'h0);
    chk("rst_busy_rdy", 32'({busy, cmd_ready}), 32'h0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("idle_rdy", 32'(cmd_ready), 32'd1);

    // Asynchronous reset in the middle of the write strobe.
    issue(1'b0, 1'b0, 8'h55, "abort_acc");
    for (int i = 0; i < 20; i++) begin
      if (!WR_n) break;
      @(negedge CLK);
    end
    chk("abort_wr_low_seen", 32'(WR_n), 32'd0);
    #1 RESET = 1'b1;
    #1;
    chk("abort_async_strobes", 32'({WR_n, CS_n}), 32'h3);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("abort_busy", 32'(busy), 32'd0);

    // Initialisation writes.
    do_write(1'b0, 8'h13, "icw1");
    do_write(1'b1, 8'h20, "icw2");
    do_write(1'b1, 8'h01, "icw4");
    chk("wr_count", 32'(wr_idx), 32'd3);
    chk("log_icw1", 32'({wr_a0_log[0], wr_dat_log[0]}), 32'h013);
    chk("log_icw2", 32'({wr_a0_log[1], wr_dat_log[1]}), 32'h120);
    chk("log_icw4", 32'({wr_a0_log[2], wr_dat_log[2]}), 32'h101);

    // Status read.
    s_rd = rd_low_tot; s_r = rdv_tot; s_cs = cs_low_tot;
    issue(1'b1, 1'b1, 8'h00, "rd_acc");
    wait_idle("rd_idle");
    repeat (2) @(negedge CLK);
    chk("rd_low", 32'(rd_low_tot - s_rd), 32'd2);
    chk("rd_cs_low", 32'(cs_low_tot - s_cs), 32'd2);
    chk("rd_valid_pulses", 32'(rdv_tot - s_r), 32'd1);
    chk("rd_data", 32'(rd_data), 32'hA5);

    // Interrupt acknowledge with IR3.
    int_enable = 1'b1;
    s_f = inta_fall; s_v = vecv_tot;
    INT = 1'b1;
    wait_vec("ack_vec_seen");
    INT = 1'b0;
    wait_idle("ack_idle");
    repeat (20) @(negedge CLK);
    chk("ack_pulse1", 32'(low_len_a), 32'd2);
    chk("ack_gap", 32'(gap_len), 32'd2);
    chk("ack_pulse2", 32'(low_len_b), 32'd2);
    chk("ack_vec_data", 32'(vec_data), 32'h23);
    chk("ack_vec_pulses", 32'(vecv_tot - s_v), 32'd1);
    chk("ack_inta_falls", 32'(inta_fall - s_f), 32'd2);

    // Same-cycle command and synchronized INT: acknowledge first.
    s_f = inta_fall;
    INT = 1'b1;
    repeat (2) @(negedge CLK);
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'hF7;
    #1;
    chk("arb_rdy_low", 32'(cmd_ready), 32'd0);
    fork
      issue(1'b0, 1'b1, 8'hF7, "arb_acc");
      begin
        wait_vec("arb_vec_seen");
        INT = 1'b0;
      end
    join
    wait_idle("arb_idle");
    repeat (2) @(negedge CLK);
    chk("arb_inta_falls", 32'(inta_fall - s_f), 32'd2);
    chk("arb_write_start", 32'(cs_fall_cyc - vec_cyc), 32'd6);
    chk("arb_write_log", 32'({wr_a0_log[3], wr_dat_log[3]}), 32'h1F7);

    // INT ignored while interrupts are disabled.
    int_enable = 1'b0;
    s_f = inta_fall;
    INT = 1'b1;
    repeat (20) @(negedge CLK);
    chk("dis_no_inta", 32'(inta_fall - s_f), 32'd0);
    chk("dis_busy", 32'(busy), 32'd0);
    INT = 1'b0;
    repeat (3) @(negedge CLK);

    // INT and enable dropped during the gap; sequence still completes.
    int_enable = 1'b1;
    s_f = inta_fall; s_v = vecv_tot;
    INT = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (inta_fall - s_f == 1 && INTA_n) break;
      @(negedge CLK);
    end
    chk("drop_in_gap", 32'({INTA_n, 8'(inta_fall - s_f)}), 32'h101);
    INT = 1'b0;
    int_enable = 1'b0;
    wait_vec("drop_vec_seen");
    wait_idle("drop_idle");
    repeat (20) @(negedge CLK);
    chk("drop_vec_pulses", 32'(vecv_tot - s_v), 32'd1);
    chk("drop_inta_falls", 32'(inta_fall - s_f), 32'd2);
    chk("drop_vec_data", 32'(vec_data), 32'h23);

    chk("strobe_overlap", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
